// File: rtl/act_buf_pkg.sv
`default_nettype none
// ============================================================================
// act_buf_pkg : shared constants, read-FSM states and helpers for the buffer
// Rev 1.0
// ============================================================================
package act_buf_pkg;

  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 8;
  localparam int DEF_AW     = 7;
  localparam int DEF_CPC    = 3;
  localparam int DEF_NSLOT  = DEF_COLS * DEF_CPC;

  localparam int DEF_ADDR_W = $clog2(DEF_ROWS * DEF_COLS);
  localparam int DEF_ROW_W  = $clog2(DEF_ROWS);
  localparam int DEF_COL_W  = $clog2(DEF_COLS);
  localparam int DEF_PTR_W  = $clog2(DEF_NSLOT + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  function automatic int round_up(input int v, input int m);
    return ((v + m - 1) / m) * m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_bank.sv
`default_nettype none
// ============================================================================
// act_bank : one activation tile plus compensation-row slots and column mux
// Rev 1.0
// ============================================================================
module act_bank
  import act_buf_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int AW   = DEF_AW,
  parameter int CPC  = DEF_CPC,
  localparam int NSLOT = COLS * CPC,
  localparam int AAW   = $clog2(ROWS * COLS),
  localparam int RW    = $clog2(ROWS),
  localparam int CW    = $clog2(COLS),
  localparam int SW    = $clog2(NSLOT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AAW-1:0]        wr_addr,
  input  logic [AW-1:0]         wr_data,
  input  logic                  cmp_en,
  input  logic [SW-1:0]         cmp_slot,
  input  logic [RW-1:0]         cmp_row,
  input  logic                  clr_valid,
  input  logic [CW-1:0]         rd_col,
  output logic [ROWS*AW-1:0]    rd_act,
  output logic [NSLOT*AW-1:0]   rd_cmp,
  output logic [NSLOT-1:0]      rd_mask
);

  logic [AW-1:0]    mem  [ROWS*COLS];
  logic [RW-1:0]    crow [NSLOT];
  logic [NSLOT-1:0] valid;

  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_addr]   <= wr_data;
    if (cmp_en) crow[cmp_slot] <= cmp_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            valid           <= '0;
    else if (clr_valid) valid           <= '0;
    else if (cmp_en)    valid[cmp_slot] <= 1'b1;
  end

  // Compensation slots pick a row out of the same column being streamed.
  always_comb begin
    rd_act = '0;
    rd_cmp = '0;
    for (int r = 0; r < ROWS; r++)
      rd_act[r*AW +: AW] = mem[AAW'(int'(rd_col) * ROWS + r)];
    for (int s = 0; s < NSLOT; s++)
      if (valid[s])
        rd_cmp[s*AW +: AW] = mem[AAW'(int'(rd_col) * ROWS + int'(crow[s]))];
  end

  assign rd_mask = valid;

endmodule
`default_nettype wire

// File: rtl/activation_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// activation_pingpong_buffer : double-buffered activation tile feeding a
// systolic array column by column. Rev 1.0
// ============================================================================
module activation_pingpong_buffer
  import act_buf_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int AW   = DEF_AW,
  parameter int CPC  = DEF_CPC,
  localparam int NSLOT = COLS * CPC,
  localparam int AAW   = $clog2(ROWS * COLS),
  localparam int RW    = $clog2(ROWS),
  localparam int CW    = $clog2(COLS),
  localparam int SW    = $clog2(NSLOT),
  localparam int PW    = $clog2(NSLOT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [AAW-1:0]        wr_addr,
  input  logic [AW-1:0]         wr_data,
  input  logic                  cmp_valid,
  input  logic [RW-1:0]         cmp_row,
  input  logic                  col_done,
  input  logic                  load_done,
  output logic                  wr_ready,
  input  logic                  cal_start,
  output logic                  out_valid,
  output logic [CW-1:0]         out_col,
  output logic [ROWS*AW-1:0]    act_out,
  output logic [NSLOT*AW-1:0]   act_cout,
  output logic [NSLOT-1:0]      cout_mask,
  output logic                  err
);

  logic             wb, rb;
  logic [1:0]       full, full_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic             err_n;
  rd_state_t        state;
  logic             cmp_acc, load_acc, rel;
  logic [CW-1:0]    rd_col;
  int               p_next;

  logic [ROWS*AW-1:0]  bank_act  [2];
  logic [NSLOT*AW-1:0] bank_cmp  [2];
  logic [NSLOT-1:0]    bank_mask [2];

  assign wr_ready = !full[wb];
  assign cmp_acc  = wr_ready && cmp_valid && (ptr != PW'(NSLOT));
  assign load_acc = wr_ready && load_done;
  assign rel      = (state == ST_STREAM) && (out_col == CW'(COLS - 1));
  // The mux looks one column ahead so outputs can be registered.
  assign rd_col   = (state == ST_STREAM) ? out_col + 1'b1 : '0;

  // A bank's slots are emptied whenever it becomes writable again, never while full.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .CPC(CPC)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_valid && wr_ready && (wb == 1'(b))),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cmp_en    (cmp_acc && (wb == 1'(b))),
      .cmp_slot  (SW'(ptr)),
      .cmp_row   (cmp_row),
      .clr_valid ((load_acc && (wb != 1'(b)) && !full[b]) || (rel && (rb == 1'(b)))),
      .rd_col    (rd_col),
      .rd_act    (bank_act[b]),
      .rd_cmp    (bank_cmp[b]),
      .rd_mask   (bank_mask[b])
    );
  end

  always_comb begin
    p_next = int'(ptr);
    if (cmp_acc)              p_next = p_next + 1;
    if (wr_ready && col_done) p_next = round_up(p_next, CPC);
    if (load_acc)             p_next = 0;
    ptr_n = PW'(p_next);

    full_n = full;
    if (rel)      full_n[rb] = 1'b0;
    if (load_acc) full_n[wb] = 1'b1;

    err_n = err;
    if (!wr_ready && (wr_valid || cmp_valid || col_done || load_done)) err_n = 1'b1;
    if (wr_ready && cmp_valid && !cmp_acc)                             err_n = 1'b1;
    if ((state == ST_IDLE) && cal_start && !full[rb])                  err_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb   <= 1'b0;
      full <= '0;
      ptr  <= '0;
      err  <= 1'b0;
    end else begin
      ptr  <= ptr_n;
      full <= full_n;
      err  <= err_n;
      if (load_acc) wb <= ~wb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rb        <= 1'b0;
      out_valid <= 1'b0;
      out_col   <= '0;
      act_out   <= '0;
      act_cout  <= '0;
      cout_mask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cal_start && full[rb]) begin
            state     <= ST_STREAM;
            out_valid <= 1'b1;
            out_col   <= '0;
            act_out   <= bank_act[rb];
            act_cout  <= bank_cmp[rb];
            cout_mask <= bank_mask[rb];
          end
        end
        ST_STREAM: begin
          if (rel) begin
            state     <= ST_IDLE;
            rb        <= ~rb;
            out_valid <= 1'b0;
            out_col   <= '0;
            act_out   <= '0;
            act_cout  <= '0;
            cout_mask <= '0;
          end else begin
            out_col   <= rd_col;
            act_out   <= bank_act[rb];
            act_cout  <= bank_cmp[rb];
            cout_mask <= bank_mask[rb];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_activation_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// tb_activation_pingpong_buffer : directed stimulus against a bank/queue model
// Rev 1.0
// ============================================================================
module tb_activation_pingpong_buffer;
  import act_buf_pkg::*;

  localparam int ROWS  = DEF_ROWS;
  localparam int COLS  = DEF_COLS;
  localparam int AW    = DEF_AW;
  localparam int CPC   = DEF_CPC;
  localparam int NSLOT = DEF_NSLOT;
  localparam int DEPTH = ROWS * COLS;

  logic clk = 1'b0;
  logic rst, wr_valid, cmp_valid, col_done, load_done, cal_start;
  logic [DEF_ADDR_W-1:0] wr_addr;
  logic [AW-1:0]         wr_data;
  logic [DEF_ROW_W-1:0]  cmp_row;
  logic                  wr_ready, out_valid, err;
  logic [DEF_COL_W-1:0]  out_col;
  logic [ROWS*AW-1:0]    act_out;
  logic [NSLOT*AW-1:0]   act_cout;
  logic [NSLOT-1:0]      cout_mask;

  activation_pingpong_buffer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmp_valid(cmp_valid), .cmp_row(cmp_row), .col_done(col_done), .load_done(load_done),
    .wr_ready(wr_ready), .cal_start(cal_start), .out_valid(out_valid), .out_col(out_col),
    .act_out(act_out), .act_cout(act_cout), .cout_mask(cout_mask), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DEF_COL_W-1:0] col;
    logic [ROWS*AW-1:0]   act;
    logic [NSLOT*AW-1:0]  cout;
    logic [NSLOT-1:0]     mask;
  } beat_t;

  logic [AW-1:0]        m_mem  [2][DEPTH];
  logic [DEF_ROW_W-1:0] m_crow [2][NSLOT];
  logic [NSLOT-1:0]     m_vld  [2];
  bit [1:0] m_full;
  bit       m_wb, m_rb, m_err, m_ready;
  int       m_ptr;
  beat_t    q[$];
  beat_t    cur;
  bit       m_ov;

  function automatic beat_t zero_beat();
    beat_t b;
    b.col = '0; b.act = '0; b.cout = '0; b.mask = '0;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = '0; m_wb = 0; m_rb = 0; m_err = 0; m_ptr = 0; m_ov = 0;
      m_vld[0] = '0; m_vld[1] = '0;
      q.delete();
      cur = zero_beat();
    end else begin
      m_ready = !m_full[m_wb];
      // read side: a stream is a snapshot of the bank taken when it is accepted
      if (m_ov) begin
        if (q.size() == 0) begin
          m_ov = 0; cur = zero_beat();
          m_full[m_rb] = 0; m_vld[m_rb] = '0; m_rb = ~m_rb;
        end else cur = q.pop_front();
      end else if (cal_start) begin
        if (m_full[m_rb]) begin
          for (int c = 0; c < COLS; c++) begin
            beat_t b;
            b.col = DEF_COL_W'(c);
            b.mask = m_vld[m_rb];
            b.act = '0; b.cout = '0;
            for (int r = 0; r < ROWS; r++) b.act[r*AW +: AW] = m_mem[m_rb][c*ROWS + r];
            for (int s = 0; s < NSLOT; s++)
              if (m_vld[m_rb][s]) b.cout[s*AW +: AW] = m_mem[m_rb][c*ROWS + int'(m_crow[m_rb][s])];
            q.push_back(b);
          end
          cur = q.pop_front();
          m_ov = 1;
        end else m_err = 1;
      end
      // write side
      if (!m_ready) begin
        if (wr_valid || cmp_valid || col_done || load_done) m_err = 1;
      end else begin
        if (wr_valid) m_mem[m_wb][wr_addr] = wr_data;
        if (cmp_valid) begin
          if (m_ptr == NSLOT) m_err = 1;
          else begin
            m_crow[m_wb][m_ptr] = cmp_row; m_vld[m_wb][m_ptr] = 1'b1; m_ptr++;
          end
        end
        if (col_done) m_ptr = ((m_ptr + CPC - 1) / CPC) * CPC;
        if (load_done) begin
          m_full[m_wb] = 1; m_wb = ~m_wb; m_ptr = 0;
          if (!m_full[m_wb]) m_vld[m_wb] = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", out_valid, m_ov);
      chk("out_col",   out_col,   cur.col);
      chk("act_out",   act_out,   cur.act);
      chk("act_cout",  act_cout,  cur.cout);
      chk("cout_mask", cout_mask, cur.mask);
      chk("wr_ready",  wr_ready,  !m_full[m_wb]);
      chk("err",       err,       m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #2; endtask

  task automatic wr(input int a, input int d);
    wr_valid = 1; wr_addr = DEF_ADDR_W'(a); wr_data = AW'(d);
    tick(); wr_valid = 0;
  endtask

  task automatic cmp(input int row, input bit done);
    cmp_valid = 1; cmp_row = DEF_ROW_W'(row); col_done = done;
    tick(); cmp_valid = 0; col_done = 0;
  endtask

  task automatic pulse_col_done();  col_done = 1;  tick(); col_done = 0;  endtask
  task automatic pulse_load_done(); load_done = 1; tick(); load_done = 0; endtask
  task automatic pulse_cal_start(); cal_start = 1; tick(); cal_start = 0; endtask
  task automatic do_reset();        rst = 1; tick(); rst = 0; tick();     endtask

  task automatic wait_idle();
    int n = 0;
    while (out_valid && n < 40) begin tick(); n++; end
    chk("stream_end_timeout", out_valid, 1'b0);
  endtask

  task automatic wait_col(input int c);
    int n = 0;
    while (!(out_valid && out_col == DEF_COL_W'(c)) && n < 40) begin tick(); n++; end
    chk("reach_col_timeout", out_valid && (out_col == DEF_COL_W'(c)), 1'b1);
  endtask

  initial begin
    rst = 1; wr_valid = 0; cmp_valid = 0; col_done = 0; load_done = 0; cal_start = 0;
    wr_addr = '0; wr_data = '0; cmp_row = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_on = 1;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 0; tick();

    // bank0: mem[i]=i, compensation rows 2,5,7 for column 0
    for (int i = 0; i < DEPTH; i++) wr(i, i);
    cmp(2, 0); cmp(5, 0); cmp(7, 0);
    pulse_load_done();
    pulse_cal_start();
    chk("t1_first_valid", out_valid, 1'b1);
    chk("t1_col0", out_col, 0);
    chk("t1_act", act_out, {7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0});
    chk("t1_cout", act_cout[20:0], {7'd7, 7'd5, 7'd2});
    chk("t1_mask", cout_mask, 24'h7);
    wait_idle();

    // bank1: cmp, cmp, col_done, cmp leaves slot 2 empty
    for (int i = 0; i < DEPTH; i++) wr(i, (i + 10) % 128);
    cmp(1, 0); cmp(3, 0); pulse_col_done(); cmp(4, 0);
    pulse_load_done();
    pulse_cal_start();
    chk("t2_mask", cout_mask, 24'hB);
    chk("t2_slot0", act_cout[6:0], 11);
    chk("t2_slot1", act_cout[13:7], 13);
    chk("t2_slot2", act_cout[20:14], 0);
    chk("t2_slot3", act_cout[27:21], 14);
    wait_idle();

    // bank0 with same-cycle cmp+col_done and boundary col_done; bank1 loads meanwhile
    for (int i = 0; i < DEPTH; i++) wr(i, (i * 3) % 128);
    cmp(6, 1); cmp(0, 0); pulse_col_done(); pulse_col_done(); cmp(7, 0);
    pulse_load_done();
    for (int i = 0; i < DEPTH; i++) wr(i, i ^ 85);
    cmp(2, 0);
    pulse_cal_start();
    cmp(5, 0);
    wait_col(7);
    pulse_load_done();
    pulse_cal_start();
    chk("t3_second_valid", out_valid, 1'b1);
    chk("t3_second_col0", out_col, 0);
    chk("t3_no_err", err, 1'b0);
    chk("t3_released_ready", wr_ready, 1'b1);
    chk("t3_act_r0", act_out[6:0], 85);
    chk("t3_act_r1", act_out[13:7], 84);
    chk("t3_slot0", act_cout[6:0], 87);
    chk("t3_slot1", act_cout[13:7], 80);
    chk("t3_mask", cout_mask, 24'h3);
    wr(3, 99);
    wait_idle();

    // both banks full: a further write is dropped and flagged
    for (int i = 0; i < DEPTH; i++) wr(i, 127 - i);
    pulse_load_done();
    pulse_load_done();
    chk("t4_not_ready", wr_ready, 1'b0);
    wr(5, 1);
    chk("t4_err", err, 1'b1);
    pulse_cal_start();
    chk("t4_row5_kept", act_out[41:35], 122);
    wait_idle();
    pulse_cal_start();
    wait_idle();

    // cal_start with nothing loaded
    do_reset();
    pulse_cal_start();
    chk("t5_no_stream", out_valid, 1'b0);
    chk("t5_err", err, 1'b1);

    // slot pointer exhaustion
    do_reset();
    for (int i = 0; i < NSLOT; i++) cmp(i % ROWS, 0);
    chk("t6_full_slots_ok", err, 1'b0);
    cmp(1, 0);
    chk("t6_overflow_err", err, 1'b1);

    // reset in the middle of a stream
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(i, i + 1);
    pulse_load_done();
    pulse_cal_start();
    wait_col(3);
    rst = 1; tick();
    chk("t7_abort_valid", out_valid, 1'b0);
    chk("t7_ready", wr_ready, 1'b1);
    rst = 0; tick();
    pulse_cal_start();
    chk("t7_empty_after_rst", out_valid, 1'b0);
    chk("t7_err", err, 1'b1);
    tick();

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
